// File: rtl/arith_extend_arbiter.sv
// Round-robin arbiter sharing one fixed-latency extender lane among requesters.
// Results return in grant order through a credit-protected FWFT buffer.
module arith_extend_arbiter #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int REQS    = 4,
  parameter int EXT_LAT = 1,
  parameter int ID_W    = $clog2(REQS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REQS-1:0]        req_valid,
  output logic [REQS-1:0]        req_ready,
  input  logic [REQS*IN_W-1:0]   req_data,
  input  logic [REQS-1:0]        req_sign,
  output logic [IN_W-1:0]        ext_in,
  output logic                   ext_sign,
  input  logic [OUT_W-1:0]       ext_out,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [OUT_W-1:0]       resp_data
);

  localparam int C  = EXT_LAT + 1;
  localparam int CW = $clog2(C + 1);
  localparam int PW = $clog2(C);
  localparam logic [CW-1:0] CAP = CW'(C);
  localparam logic [PW-1:0] LASTP = PW'(C - 1);

  logic [ID_W-1:0] last_q, last_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]   wp_q, wp_d;
  logic [PW-1:0]   rp_q, rp_d;

  logic [EXT_LAT-1:0] pv_q;
  logic [ID_W-1:0]    pid_q [EXT_LAT];

  logic [OUT_W-1:0] fd_q [C];
  logic [ID_W-1:0]  fi_q [C];

  logic            pop;
  logic            push;
  logic [ID_W-1:0] push_id;
  logic            issue_ok;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] cand;
  logic            grant;
  int              arb_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LASTP) ? '0 : p + 1'b1;
  endfunction

  assign pop     = resp_valid && resp_ready;
  assign push    = pv_q[EXT_LAT-1];
  assign push_id = pid_q[EXT_LAT-1];

  // A pop at full occupancy frees a credit in the same cycle.
  assign issue_ok = !rst &&
    ((count_q < CAP) || ((count_q == CAP) && pop));

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    arb_idx = 0;
    cand    = '0;
    for (int k = 1; k <= REQS; k++) begin
      arb_idx = (int'(last_q) + k) % REQS;
      cand    = ID_W'(arb_idx);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign grant = issue_ok && gnt_vld;

  always_comb begin
    req_ready = '0;
    ext_in    = '0;
    ext_sign  = 1'b0;
    if (grant) begin
      req_ready[gnt_id] = 1'b1;
      ext_in   = req_data[int'(gnt_id)*IN_W +: IN_W];
      ext_sign = req_sign[gnt_id];
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant) begin
      last_d = gnt_id;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    fcnt_d = fcnt_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (push) begin
      wp_d = ptr_inc(wp_q);
    end
    if (pop) begin
      rp_d = ptr_inc(rp_q);
    end
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= ID_W'(REQS - 1);
      count_q <= '0;
      fcnt_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      last_q  <= last_d;
      count_q <= count_d;
      fcnt_q  <= fcnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  // In-flight tags travel alongside the extender's own pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      for (int i = 0; i < EXT_LAT; i++) begin
        pid_q[i] <= '0;
      end
    end else begin
      pv_q[0]  <= grant;
      pid_q[0] <= gnt_id;
      for (int i = 1; i < EXT_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fd_q[wp_q] <= ext_out;
      fi_q[wp_q] <= push_id;
    end
  end

  assign resp_valid = (fcnt_q != '0);
  assign resp_id    = fi_q[rp_q];
  assign resp_data  = fd_q[rp_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (fcnt_q == CAP) && !pop));

  a_onehot_ready: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= CAP);

endmodule
